mem_access_unit: RTL and testbench

- Load/store sequencer between the multicycle datapath and a synchronous single-port data memory.
- On a request it does the following:
  - checks alignment;
  - generates byte enables and lane-shifted write data for SB/SH/SW;
  - waits out the memory's fixed read latency;
  - captures and sign/zero-extends load data (LB/LH/LW/LBU/LHU) into a held result register.
- Lets the control FSM replace ad-hoc memory-wait states with a single done handshake.

---
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and a synchronous single-port data memory
module mem_access_unit #(
   parameter int ADDR_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fault,
   output logic [31:0]           rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);
   logic [1:0]            state_q, state_d;
   logic                  write_q, fault_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q, rdata_q, ld_ext, st_wd;
   logic [1:0]            cnt_q;
   logic [3:0]            st_be;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   logic                  f3_ok, al_ok, req_ok, issue;
   assign f3_ok  = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                             : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign al_ok  = (req_funct3[1:0] == 2'b00) ||
                   (req_funct3[1:0] == 2'b01 && !req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
   assign req_ok = f3_ok && al_ok;
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid) state_d = req_ok ? S_ISSUE : S_DONE;
         S_ISSUE: state_d = write_q ? S_DONE : S_WAIT;
         S_WAIT:  if (cnt_q == 2'd0) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   // Load data: pick the addressed lane, then extend per funct3.
   assign ld_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign ld_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign ld_ext = (funct3_q == 3'b000) ? {{24{ld_b[7]}}, ld_b} :
                   (funct3_q == 3'b001) ? {{16{ld_h[15]}}, ld_h} :
                   (funct3_q == 3'b100) ? {24'd0, ld_b} :
                   (funct3_q == 3'b101) ? {16'd0, ld_h} : mem_rdata;
   assign st_be  = (funct3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                   (funct3_q[1:0] == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign st_wd  = (funct3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                   (funct3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         fault_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         cnt_q    <= 2'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            fault_q  <= !req_ok;
         end
         if (state_q == S_ISSUE) cnt_q <= CNT_INIT;
         else if (state_q == S_WAIT) cnt_q <= cnt_q - 2'd1;
         if (state_q == S_WAIT && cnt_q == 2'd0) rdata_q <= ld_ext;
      end
   end
   assign issue     = (state_q == S_ISSUE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign fault     = done && fault_q;
   assign rdata     = rdata_q;
   assign mem_en    = issue;
   assign mem_we    = issue && write_q;
   assign mem_be    = issue ? (write_q ? st_be : 4'b1111) : 4'b0000;
   assign mem_wdata = (issue && write_q) ? st_wd : 32'd0;
   assign mem_addr  = addr_q[ADDR_WIDTH-1:2];
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of three instances (READ_LATENCY 1, 3, 4) against a shared memory model
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        busy_w [3], done_w [3], fault_w [3], en_w [3], we_w [3];
   logic [3:0]  be_w [3];
   logic [29:0] addr_w [3];
   logic [31:0] wd_w [3], rd_w [3], mrd_w [3];
   logic [31:0] mem [0:127];
   int          n_cmp = 0, n_bad = 0;
   logic [10:0] done_m [3];
   logic [10:0] en_m;
   logic        flt [3];
   logic        c1_en, c1_we;
   logic [3:0]  c1_be;
   logic [29:0] c1_addr;
   logic [31:0] c1_wd;
   always #5 clk = ~clk;
   genvar g;
   for (g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
      logic [31:0] pipe [0:3];
      mem_access_unit #(.ADDR_WIDTH(32), .READ_LATENCY(L)) u_dut (
         .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
         .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
         .busy(busy_w[g]), .done(done_w[g]), .fault(fault_w[g]), .rdata(rd_w[g]),
         .mem_en(en_w[g]), .mem_we(we_w[g]), .mem_be(be_w[g]), .mem_addr(addr_w[g]),
         .mem_wdata(wd_w[g]), .mem_rdata(mrd_w[g]));
      // Read data is only valid exactly L cycles after the strobe; zeros otherwise.
      always_ff @(posedge clk) begin
         pipe[0] <= (en_w[g] && !we_w[g]) ? mem[addr_w[g][6:0]] : 32'h0;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign mrd_w[g] = pipe[L-1];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
         mem[64] <= 32'h80FF7F01;
      end else if (en_w[0] && we_w[0]) begin
         for (int b = 0; b < 4; b++)
            if (be_w[0][b]) mem[addr_w[0][6:0]][8*b +: 8] <= wd_w[0][8*b +: 8];
      end
   end
   function automatic int lat(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 4;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input bit hold);
      req_write = w; req_funct3 = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin done_m[i] = '0; flt[i] = 1'b0; end
      en_m = '0;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == (hold ? 4 : 1)) req_valid = 1'b0;
         if (k == 1) begin
            c1_en = en_w[0]; c1_we = we_w[0]; c1_be = be_w[0]; c1_addr = addr_w[0]; c1_wd = wd_w[0];
         end
         en_m[k] = en_w[0];
         for (int i = 0; i < 3; i++) begin
            done_m[i][k] = done_w[i];
            if (done_w[i]) flt[i] = fault_w[i];
         end
      end
   endtask
   task automatic ld(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
      logic [10:0] m;
      run(1'b0, f, a, 32'h0, 1'b0);
      check({tag, " en"}, 32'(c1_en), 32'd1);
      check({tag, " we"}, 32'(c1_we), 32'd0);
      check({tag, " be"}, 32'(c1_be), 32'hF);
      check({tag, " addr"}, 32'(c1_addr), 32'(a[31:2]));
      for (int i = 0; i < 3; i++) begin
         m = 11'd1 << (2 + lat(i));
         check({tag, " done L", $sformatf("%0d", lat(i))}, 32'(done_m[i]), 32'(m));
         check({tag, " fault L", $sformatf("%0d", lat(i))}, 32'(flt[i]), 32'd0);
         check({tag, " rdata L", $sformatf("%0d", lat(i))}, rd_w[i], exp);
      end
   endtask
   task automatic st(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] prev;
      prev = rd_w[0];
      run(1'b1, f, a, d, 1'b0);
      check({tag, " en"}, 32'(c1_en), 32'd1);
      check({tag, " we"}, 32'(c1_we), 32'd1);
      check({tag, " be"}, 32'(c1_be), 32'(be));
      check({tag, " addr"}, 32'(c1_addr), 32'(a[31:2]));
      check({tag, " wdata"}, c1_wd, wd);
      check({tag, " done"}, 32'(done_m[0]), 32'h004);
      check({tag, " fault"}, 32'(flt[0]), 32'd0);
      check({tag, " rdata kept"}, rd_w[0], prev);
   endtask
   task automatic bad(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a);
      logic [31:0] prev [3];
      for (int i = 0; i < 3; i++) prev[i] = rd_w[i];
      run(w, f, a, 32'h5555AAAA, 1'b0);
      check({tag, " no strobe"}, 32'(en_m), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check({tag, " done"}, 32'(done_m[i]), 32'h002);
         check({tag, " fault"}, 32'(flt[i]), 32'd1);
         check({tag, " rdata kept"}, rd_w[i], prev[i]);
      end
   endtask
   initial begin
      logic seen;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst busy", 32'(busy_w[0]), 32'd0);
      check("rst done", 32'(done_w[0]), 32'd0);
      check("rst fault", 32'(fault_w[0]), 32'd0);
      check("rst rdata", rd_w[0], 32'd0);
      check("rst mem_en", 32'(en_w[0]), 32'd0);
      check("rst mem_we", 32'(we_w[0]), 32'd0);
      check("rst mem_be", 32'(be_w[0]), 32'd0);
      check("rst mem_addr", 32'(addr_w[0]), 32'd0);
      check("rst mem_wdata", wd_w[0], 32'd0);
      @(negedge clk);
      ld("LB102", 3'b000, 32'h102, 32'hFFFFFFFF);
      ld("LBU102", 3'b100, 32'h102, 32'h000000FF);
      ld("LB100", 3'b000, 32'h100, 32'h00000001);
      ld("LH102", 3'b001, 32'h102, 32'hFFFF80FF);
      ld("LHU102", 3'b101, 32'h102, 32'h000080FF);
      ld("LW100", 3'b010, 32'h100, 32'h80FF7F01);
      bad("LW102", 1'b0, 3'b010, 32'h102);
      bad("SH101", 1'b1, 3'b001, 32'h101);
      bad("S f3=100", 1'b1, 3'b100, 32'h100);
      bad("L f3=011", 1'b0, 3'b011, 32'h100);
      st("SW104", 3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      ld("LW104", 3'b010, 32'h104, 32'hDEADBEEF);
      st("SB103", 3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
      st("SH102", 3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
      st("SB101", 3'b000, 32'h101, 32'h0000005A, 4'b0010, 32'h5A5A5A5A);
      ld("LW100 after", 3'b010, 32'h100, 32'h12345A01);
      run(1'b1, 3'b010, 32'h108, 32'h11223344, 1'b1);
      check("hold strobes", 32'(en_m), 32'h012);
      check("hold dones", 32'(done_m[0]), 32'h024);
      req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre-rst busy L4", 32'(busy_w[2]), 32'd1);
      reset = 1'b1;
      #1;
      check("mid-rst busy L4", 32'(busy_w[2]), 32'd0);
      check("mid-rst done L4", 32'(done_w[2]), 32'd0);
      check("mid-rst rdata L4", rd_w[2], 32'd0);
      check("mid-rst mem_be L4", 32'(be_w[2]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | done_w[1] | done_w[2];
      end
      check("post-rst no done", 32'(seen), 32'd0);
      check("post-rst rdata L3", rd_w[1], 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
